lockable_reg_bank: RTL and testbench

- Parametrised bank of NUM_REGS lockable configuration registers.
- Each register has its own sticky lock bit.
- Locked registers can be overridden only through an authenticated debug-unlock state machine with attempt counting and permanent lockout.
- While scan_mode is high, register contents are zeroed and all writes are blocked. Scan therefore gives no write path into locked registers.

---
 rtl/lockable_reg_pkg.sv | 18 +
 rtl/dbg_unlock_fsm.sv | 82 ++++++++
 rtl/lockable_reg_bank.sv | 111 +++++++++++
 tb/tb_lockable_reg_bank.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/lockable_reg_pkg.sv
// Shared types and constants for the lockable register bank.
package lockable_reg_pkg;

    // Debug unlock session states.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CHECK    = 2'd1,
        UNLOCKED = 2'd2,
        LOCKOUT  = 2'd3
    } dbg_state_e;

    // Factory debug key.
    localparam logic [31:0] DEFAULT_UNLOCK_KEY = 32'hC0DE_5EC1;

    // Fail counter width, wide enough for the largest attempt limit (15).
    localparam int FAIL_CNT_W = 4;

endpackage

// File: rtl/dbg_unlock_fsm.sv
// Debug unlock state machine: latches a submitted key, compares it one
// cycle later, counts failures and locks out permanently (until reset)
// once the attempt budget is spent. Outputs are registered state decodes.
module dbg_unlock_fsm
    import lockable_reg_pkg::*;
#(
    parameter int                KEY_W        = 32,
    parameter logic [KEY_W-1:0]  UNLOCK_KEY   = KEY_W'(DEFAULT_UNLOCK_KEY),
    parameter int                MAX_ATTEMPTS = 3
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             scan_mode_i,
    input  logic             dbg_req_i,
    input  logic [KEY_W-1:0] dbg_key_i,
    input  logic             dbg_exit_i,
    output logic             dbg_unlocked_o,
    output logic             dbg_lockout_o
);

    dbg_state_e             state_q, state_d;
    logic [KEY_W-1:0]       key_q, key_d;
    logic [FAIL_CNT_W-1:0]  fail_q, fail_d;
    logic                   unlocked_q, lockout_q;

    // Next-state logic; scan drops any session except a lockout.
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        fail_d  = fail_q;
        unique case (state_q)
            IDLE: begin
                if (dbg_req_i && !scan_mode_i) begin
                    key_d   = dbg_key_i;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (scan_mode_i) begin
                    state_d = IDLE;
                end else if (key_q == UNLOCK_KEY) begin
                    state_d = UNLOCKED;
                    fail_d  = '0;
                end else begin
                    if (fail_q != {FAIL_CNT_W{1'b1}})
                        fail_d = fail_q + FAIL_CNT_W'(1);
                    if (fail_q + FAIL_CNT_W'(1) == FAIL_CNT_W'(MAX_ATTEMPTS))
                        state_d = LOCKOUT;
                    else
                        state_d = IDLE;
                end
            end
            UNLOCKED: begin
                if (dbg_exit_i || scan_mode_i)
                    state_d = IDLE;
            end
            LOCKOUT: state_d = LOCKOUT;
            default: state_d = IDLE;
        endcase
    end

    // State, latched key, fail counter and registered output decodes.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            key_q      <= '0;
            fail_q     <= '0;
            unlocked_q <= 1'b0;
            lockout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            key_q      <= key_d;
            fail_q     <= fail_d;
            unlocked_q <= (state_d == UNLOCKED);
            lockout_q  <= (state_d == LOCKOUT);
        end
    end

    assign dbg_unlocked_o = unlocked_q;
    assign dbg_lockout_o  = lockout_q;

endmodule

// File: rtl/lockable_reg_bank.sv
// Bank of NUM_REGS configuration registers with sticky per-register locks,
// a debug unlock session that overrides locks, and scan zeroisation.
// Optional build macro LOCK_READ_MASK_EN: reads of locked registers return 0
// unless a debug session is active.
module lockable_reg_bank
    import lockable_reg_pkg::*;
#(
    parameter int                NUM_REGS     = 4,
    parameter int                DATA_W       = 16,
    parameter int                ADDR_W       = $clog2(NUM_REGS),
    parameter int                KEY_W        = 32,
    parameter logic [KEY_W-1:0]  UNLOCK_KEY   = KEY_W'(DEFAULT_UNLOCK_KEY),
    parameter int                MAX_ATTEMPTS = 3
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                wr_en_i,
    input  logic [ADDR_W-1:0]   wr_addr_i,
    input  logic [DATA_W-1:0]   wr_data_i,
    input  logic                lock_en_i,
    input  logic [ADDR_W-1:0]   lock_addr_i,
    input  logic [ADDR_W-1:0]   rd_addr_i,
    output logic [DATA_W-1:0]   rd_data_o,
    input  logic                scan_mode_i,
    input  logic                dbg_req_i,
    input  logic [KEY_W-1:0]    dbg_key_i,
    input  logic                dbg_exit_i,
    output logic                dbg_unlocked_o,
    output logic                dbg_lockout_o,
    output logic                wr_err_o,
    output logic [NUM_REGS-1:0] lock_status_o
);

    logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
    logic [NUM_REGS-1:0]             lock_q, lock_d;
    logic [DATA_W-1:0]               rd_data_q, rd_data_d;
    logic                            wr_err_q, wr_err_d;
    logic                            wr_hit, wr_locked, wr_accept;
    logic                            dbg_unlocked;

    dbg_unlock_fsm #(
        .KEY_W        (KEY_W),
        .UNLOCK_KEY   (UNLOCK_KEY),
        .MAX_ATTEMPTS (MAX_ATTEMPTS)
    ) u_dbg (
        .clk            (clk),
        .resetn         (resetn),
        .scan_mode_i    (scan_mode_i),
        .dbg_req_i      (dbg_req_i),
        .dbg_key_i      (dbg_key_i),
        .dbg_exit_i     (dbg_exit_i),
        .dbg_unlocked_o (dbg_unlocked),
        .dbg_lockout_o  (dbg_lockout_o)
    );

    // Address decode, write acceptance, read mux and next register contents.
    // Addresses that match no register are out of range and fall through.
    always_comb begin
        wr_hit    = 1'b0;
        wr_locked = 1'b0;
        rd_data_d = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_addr_i == ADDR_W'(i)) begin
                wr_hit    = 1'b1;
                wr_locked = lock_q[i];
            end
            if (rd_addr_i == ADDR_W'(i)) begin
`ifdef LOCK_READ_MASK_EN
                rd_data_d = (lock_q[i] && !dbg_unlocked) ? '0 : regs_q[i];
`else
                rd_data_d = regs_q[i];
`endif
            end
        end
        // Lock check uses the pre-edge lock bit, so a same-cycle lock lets the write land.
        wr_accept = wr_en_i && !scan_mode_i && wr_hit && (!wr_locked || dbg_unlocked);
        wr_err_d  = wr_en_i && !wr_accept;

        regs_d = regs_q;
        lock_d = lock_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (scan_mode_i)
                regs_d[i] = '0;
            else if (wr_accept && wr_addr_i == ADDR_W'(i))
                regs_d[i] = wr_data_i;
            if (lock_en_i && lock_addr_i == ADDR_W'(i))
                lock_d[i] = 1'b1;
        end
    end

    // Register bank, sticky locks, read data and write-error pulse.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            regs_q    <= '0;
            lock_q    <= '0;
            rd_data_q <= '0;
            wr_err_q  <= 1'b0;
        end else begin
            regs_q    <= regs_d;
            lock_q    <= lock_d;
            rd_data_q <= rd_data_d;
            wr_err_q  <= wr_err_d;
        end
    end

    assign rd_data_o      = rd_data_q;
    assign wr_err_o       = wr_err_q;
    assign lock_status_o  = lock_q;
    assign dbg_unlocked_o = dbg_unlocked;

endmodule

// File: tb/tb_lockable_reg_bank.sv
// Randomised and directed bench for lockable_reg_bank against a
// cycle-level behavioural model of the bank and debug session.
module tb_lockable_reg_bank;

    localparam int          NR   = 4;
    localparam int          DW   = 16;
    localparam int          AW   = 2;
    localparam int          KW   = 32;
    localparam logic [31:0] KEY  = 32'hC0DE_5EC1;
    localparam int          MAXA = 3;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          wr_en = 1'b0, lock_en = 1'b0, scan_mode = 1'b0;
    logic          dbg_req = 1'b0, dbg_exit = 1'b0;
    logic [AW-1:0] wr_addr = '0, lock_addr = '0, rd_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic [KW-1:0] dbg_key = '0;
    logic [DW-1:0] rd_data;
    logic          dbg_unlocked, dbg_lockout, wr_err;
    logic [NR-1:0] lock_status;

    always #5 clk = ~clk;

    lockable_reg_bank #(
        .NUM_REGS(NR), .DATA_W(DW), .KEY_W(KW), .UNLOCK_KEY(KEY), .MAX_ATTEMPTS(MAXA)
    ) dut (
        .clk(clk), .resetn(resetn),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .lock_en_i(lock_en), .lock_addr_i(lock_addr),
        .rd_addr_i(rd_addr), .rd_data_o(rd_data),
        .scan_mode_i(scan_mode),
        .dbg_req_i(dbg_req), .dbg_key_i(dbg_key), .dbg_exit_i(dbg_exit),
        .dbg_unlocked_o(dbg_unlocked), .dbg_lockout_o(dbg_lockout),
        .wr_err_o(wr_err), .lock_status_o(lock_status)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: register contents, lock set, session flags.
    logic [DW-1:0] mreg [NR];
    logic [NR-1:0] mlock;
    bit            munl, mlo, mpend;
    logic [KW-1:0] mkey;
    int            mfail;
    logic [DW-1:0] erd;
    bit            eerr;

    task automatic reset_model();
        for (int i = 0; i < NR; i++) mreg[i] = '0;
        mlock = '0; munl = 0; mlo = 0; mpend = 0; mkey = '0; mfail = 0;
        erd = '0; eerr = 0;
    endtask

    // Advance the model by one clock edge using the inputs sampled at that edge.
    task automatic model();
        bit acc;
        if (!resetn) begin
            reset_model();
            return;
        end
        acc  = wr_en && !scan_mode && (int'(wr_addr) < NR) && (!mlock[wr_addr] || munl);
        eerr = wr_en && !acc;
        erd  = (int'(rd_addr) < NR) ? mreg[rd_addr] : '0;
`ifdef LOCK_READ_MASK_EN
        if (int'(rd_addr) < NR && mlock[rd_addr] && !munl) erd = '0;
`endif
        if (scan_mode) begin
            for (int i = 0; i < NR; i++) mreg[i] = '0;
        end else if (acc) begin
            mreg[wr_addr] = wr_data;
        end
        if (lock_en && int'(lock_addr) < NR) mlock[lock_addr] = 1'b1;

        if (mlo) begin
            // permanent until reset
        end else if (scan_mode) begin
            mpend = 0;
            munl  = 0;
        end else if (mpend) begin
            mpend = 0;
            if (mkey == KEY) begin
                munl  = 1;
                mfail = 0;
            end else begin
                mfail++;
                if (mfail >= MAXA) mlo = 1;
            end
        end else if (munl) begin
            if (dbg_exit) munl = 0;
        end else if (dbg_req) begin
            mpend = 1;
            mkey  = dbg_key;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model();
        #1;
        chk("rd_data",      64'(rd_data),      64'(erd));
        chk("wr_err",       64'(wr_err),       64'(eerr));
        chk("dbg_unlocked", 64'(dbg_unlocked), 64'(munl));
        chk("dbg_lockout",  64'(dbg_lockout),  64'(mlo));
        chk("lock_status",  64'(lock_status),  64'(mlock));
    endtask

    task automatic idle();
        wr_en = 0; lock_en = 0; scan_mode = 0; dbg_req = 0; dbg_exit = 0;
    endtask

    task automatic submit(input logic [KW-1:0] k);
        idle(); dbg_req = 1; dbg_key = k; step();
        idle(); step();
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        idle(); wr_en = 1; wr_addr = a; wr_data = d; step();
    endtask

    task automatic rd(input logic [AW-1:0] a);
        idle(); rd_addr = a; step();
    endtask

    initial begin
        reset_model();
        step();
        chk("rst_rd",   64'(rd_data),     64'h0);
        chk("rst_lock", 64'(lock_status), 64'h0);
        chk("rst_unl",  64'(dbg_unlocked), 64'h0);
        resetn = 1;
        idle(); step();

        // Locked register keeps its value; rejected write pulses wr_err once.
        wr(2, 16'h1234);
        idle(); lock_en = 1; lock_addr = 2; step();
        wr(2, 16'hFFFF);
        chk("t1_err", 64'(wr_err), 64'h1);
        rd(2);
        chk("t1_err_once", 64'(wr_err), 64'h0);
        chk("t1_rd", 64'(rd_data), 64'h1234);

        // Correct key opens a session two cycles after dbg_req.
        idle(); lock_en = 1; lock_addr = 1; step();
        submit(KEY);
        chk("t2_unl", 64'(dbg_unlocked), 64'h1);
        wr(1, 16'hBEEF);
        chk("t2_wr_ok", 64'(wr_err), 64'h0);
        idle(); dbg_exit = 1; step();
        wr(1, 16'h1111);
        chk("t2_rej", 64'(wr_err), 64'h1);
        rd(1);
        chk("t2_rd", 64'(rd_data), 64'hBEEF);

        // Wrong keys exhaust the attempt budget; correct key then ignored.
        for (int k = 0; k < MAXA; k++) submit(KEY ^ 32'h1);
        chk("t3_lockout", 64'(dbg_lockout), 64'h1);
        submit(KEY);
        step();
        chk("t3_no_unl", 64'(dbg_unlocked), 64'h0);
        chk("t3_still_lo", 64'(dbg_lockout), 64'h1);
        idle(); resetn = 0; step();
        resetn = 1; step();
        chk("t3_lo_clr", 64'(dbg_lockout), 64'h0);

        // Scan zeroes contents and rejects writes but keeps lock bits.
        for (int i = 0; i < NR; i++) wr(AW'(i), DW'(16'h1000 + i));
        idle(); lock_en = 1; lock_addr = 0; step();
        idle(); scan_mode = 1; wr_en = 1; wr_addr = 0; wr_data = 16'h7777; step();
        chk("t4_err", 64'(wr_err), 64'h1);
        for (int i = 0; i < NR; i++) begin
            rd_addr = AW'(i); step();
            chk("t4_rd0", 64'(rd_data), 64'h0);
        end
        idle(); step();
        chk("t4_lock0", 64'(lock_status[0]), 64'h1);

        // Same-cycle write and lock: write lands, lock applies afterwards.
        idle(); wr_en = 1; wr_addr = 3; wr_data = 16'h00AA; lock_en = 1; lock_addr = 3; step();
        chk("t5_wr_ok", 64'(wr_err), 64'h0);
        wr(3, 16'h5555);
        chk("t5_rej", 64'(wr_err), 64'h1);
        rd(3);
        chk("t5_rd", 64'(rd_data), 64'h00AA);

        // Asynchronous reset mid-session clears everything before any edge.
        submit(KEY);
        chk("t6_unl", 64'(dbg_unlocked), 64'h1);
        wr(3, 16'h9999);
        rd(3);
        chk("t6_rd", 64'(rd_data), 64'h9999);
        #2 resetn = 0;
        #1;
        chk("t6_arst_unl",  64'(dbg_unlocked), 64'h0);
        chk("t6_arst_lock", 64'(lock_status),  64'h0);
        chk("t6_arst_rd",   64'(rd_data),      64'h0);
        idle(); step();
        resetn = 1;
        rd(3);
        chk("t6_reg_clr", 64'(rd_data), 64'h0);

        // Random traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            wr_en     = 1'($urandom_range(0, 1));
            wr_addr   = AW'($urandom_range(0, NR - 1));
            wr_data   = DW'($urandom);
            lock_en   = ($urandom_range(0, 29) == 0);
            lock_addr = AW'($urandom_range(0, NR - 1));
            rd_addr   = AW'($urandom_range(0, NR - 1));
            scan_mode = ($urandom_range(0, 24) == 0);
            dbg_req   = ($urandom_range(0, 7) == 0);
            dbg_key   = ($urandom_range(0, 1) == 1) ? KEY : KW'($urandom);
            dbg_exit  = ($urandom_range(0, 19) == 0);
            resetn    = ($urandom_range(0, 299) != 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
